// File: rtl/onehot_decode_seq.sv
// Registered one-hot decoder with an internal index register that can follow the
// input directly, scan up or down with a programmable dwell per step, or hold.
module onehot_decode_seq #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      in,
    output logic [(1<<SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX    = '1;

    typedef enum logic [1:0] {
        M_DECODE = 2'b00,
        M_UP     = 2'b01,
        M_DOWN   = 2'b10,
        M_HOLD   = 2'b11
    } mode_e;

    mode_e            mode_in;
    mode_e            mode_q, mode_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             restart;

    assign mode_in = mode_e'(mode);
    // A mode change, or the first enabled edge after a disabled one, starts a
    // fresh full dwell on the current index instead of stepping.
    assign restart = (mode_in != mode_q) || !valid_q;

    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        out_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        mode_d  = mode_in;

        if (!en) begin
            dwell_d = '0;
        end else begin
            valid_d = 1'b1;
            case (mode_in)
                M_DECODE: begin
                    idx_d   = in;
                    dwell_d = '0;
                end
                M_UP, M_DOWN: begin
                    if (load) begin
                        idx_d   = in;
                        dwell_d = '0;
                    end else if (restart) begin
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (mode_in == M_UP) begin
                            idx_d  = idx_q + SEL_W'(1);
                            wrap_d = (idx_q == IDX_MAX);
                        end else begin
                            idx_d  = idx_q - SEL_W'(1);
                            wrap_d = (idx_q == '0);
                        end
                    end else begin
                        dwell_d = dwell_q + CNT_W'(1);
                    end
                end
                M_HOLD: begin
                    if (load) begin
                        idx_d = in;
                    end
                    if (mode_in != mode_q) begin
                        dwell_d = '0;
                    end
                end
                default: begin
                    idx_d = idx_q;
                end
            endcase
            out_d = OUT_W'(1) << idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= M_DECODE;
            idx_q   <= '0;
            dwell_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out   = out_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_onehot_decode_seq.sv
// Directed bench for onehot_decode_seq: one instance with DWELL=4 and one with
// DWELL=1 share the same stimulus; each phase checks its own instance.
module tb_onehot_decode_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [2:0] in;

    logic [7:0] out0, out1;
    logic [2:0] idx0, idx1;
    logic       valid0, valid1, wrap0, wrap1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];

    onehot_decode_seq #(.SEL_W(3), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(in),
        .out(out0), .idx(idx0), .valid(valid0), .wrap(wrap0)
    );

    onehot_decode_seq #(.SEL_W(3), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(in),
        .out(out1), .idx(idx1), .valid(valid1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [7:0] e_out, input logic [2:0] e_idx,
                        input logic e_valid, input logic e_wrap);
        check_eq({tag, ".out"},   32'(out0),   32'(e_out));
        check_eq({tag, ".idx"},   32'(idx0),   32'(e_idx));
        check_eq({tag, ".valid"}, 32'(valid0), 32'(e_valid));
        check_eq({tag, ".wrap"},  32'(wrap0),  32'(e_wrap));
    endtask

    task automatic chk1(input string tag, input logic [7:0] e_out, input logic [2:0] e_idx,
                        input logic e_valid, input logic e_wrap);
        check_eq({tag, ".out"},   32'(out1),   32'(e_out));
        check_eq({tag, ".idx"},   32'(idx1),   32'(e_idx));
        check_eq({tag, ".valid"}, 32'(valid1), 32'(e_valid));
        check_eq({tag, ".wrap"},  32'(wrap1),  32'(e_wrap));
    endtask

    initial begin
        // reset with every other input active
        rst = 1'b1; en = 1'b1; mode = 2'b01; load = 1'b1; in = 3'd5;
        step();
        chk0("rst_a", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk0("rst_b", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // decode sweep
        exp_q = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h40, 32'h80};
        mode = 2'b00; load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in = 3'(i);
            step();
            check_eq("dec.out", 32'(out0), exp_q.pop_front());
            check_eq("dec.idx", 32'(idx0), 32'(i));
            check_eq("dec.valid", 32'(valid0), 32'd1);
        end
        en = 1'b0; in = 3'd2;
        step();
        chk0("dec_off", 8'h00, 3'd7, 1'b0, 1'b0);

        // scan up across the wrap
        en = 1'b1; mode = 2'b01; load = 1'b1; in = 3'd6;
        step();
        chk0("up_load", 8'h40, 3'd6, 1'b1, 1'b0);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk0("up_40", 8'h40, 3'd6, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk0("up_80", 8'h80, 3'd7, 1'b1, 1'b0);
        end
        step();
        chk0("up_wrap", 8'h01, 3'd0, 1'b1, 1'b1);
        step();
        chk0("up_after", 8'h01, 3'd0, 1'b1, 1'b0);

        // enable gap with idx=3, dwell_cnt=2
        load = 1'b1; in = 3'd3;
        step();
        chk0("gap_load", 8'h08, 3'd3, 1'b1, 1'b0);
        load = 1'b0;
        step();
        step();
        chk0("gap_pre", 8'h08, 3'd3, 1'b1, 1'b0);
        en = 1'b0; load = 1'b1; in = 3'd6;
        step();
        chk0("gap_off", 8'h00, 3'd3, 1'b0, 1'b0);
        en = 1'b1; load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk0("gap_08", 8'h08, 3'd3, 1'b1, 1'b0);
        end
        step();
        chk0("gap_10", 8'h10, 3'd4, 1'b1, 1'b0);

        // hold, load in hold, switch to scan down
        mode = 2'b11; load = 1'b1; in = 3'd2;
        step();
        chk0("hold_load", 8'h04, 3'd2, 1'b1, 1'b0);
        load = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk0("hold_04", 8'h04, 3'd2, 1'b1, 1'b0);
        end
        load = 1'b1; in = 3'd5;
        step();
        chk0("hold_ld5", 8'h20, 3'd5, 1'b1, 1'b0);
        load = 1'b0; mode = 2'b10;
        for (int k = 0; k < 4; k++) begin
            step();
            chk0("dn_20", 8'h20, 3'd5, 1'b1, 1'b0);
        end
        step();
        chk0("dn_10", 8'h10, 3'd4, 1'b1, 1'b0);
        rst = 1'b1; load = 1'b1; in = 3'd7;
        step();
        chk0("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
        chk1("rst_mid1", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // scan down with DWELL=1
        en = 1'b1; mode = 2'b10; load = 1'b1; in = 3'd1;
        step();
        chk1("d1_load", 8'h02, 3'd1, 1'b1, 1'b0);
        load = 1'b0;
        step();
        chk1("d1_01", 8'h01, 3'd0, 1'b1, 1'b0);
        step();
        chk1("d1_wrap", 8'h80, 3'd7, 1'b1, 1'b1);
        step();
        chk1("d1_40", 8'h40, 3'd6, 1'b1, 1'b0);
        step();
        chk1("d1_20", 8'h20, 3'd5, 1'b1, 1'b0);
        step();
        chk1("d1_10", 8'h10, 3'd4, 1'b1, 1'b0);
        // loading the wrap target must not pulse wrap
        load = 1'b1; in = 3'd7;
        step();
        chk1("d1_ld7", 8'h80, 3'd7, 1'b1, 1'b0);
        load = 1'b0;
        step();
        chk1("d1_40b", 8'h40, 3'd6, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
